usb_tx_packet_ctrl: RTL and testbench
=====================================

// Module: usb_tx_packet_ctrl
// PURPOSE
//  Packet-level sequencer for the USB transmit path (transmit_shift + transmit).
//  On a start request it feeds the shifter SYNC, PID and N payload bytes pulled from a
//  byte source, then drives EOP and reports completion.
//  It sits between the packet/AES layer and transmit_shift, on the same clock as the shifter.
// PARAMETERS
//  LEN_W      7      width of tx_len
//  MAX_LEN    64     payload byte cap; larger tx_len is clamped to MAX_LEN
//  SYNC_BYTE  8'h80  first byte of every packet
//  EOP_CYCLES 2      clocks eop is held high
// PORTS
//  clk         in   1      clock; all logic on posedge
//  n_rst       in   1      synchronous, active-low reset
//  tx_start    in   1      packet request; sampled only in IDLE
//  tx_pid      in   4      PID; latched on accepted start
//  tx_len      in   LEN_W  payload bytes; latched on accepted start
//  src_empty   in   1      byte source has no data
//  src_data    in   8      byte source head; held stable until popped
//  src_pop     out  1      1-clk pulse consuming src_data
//  shift_ready in   1      shifter can accept a byte
//  load_enable out  1      1-clk load pulse to shifter
//  tx_byte     out  8      byte to shifter; valid while load_enable=1
//  eop         out  1      end-of-packet to shifter/transmit
//  busy        out  1      packet in progress
//  done        out  1      1-clk pulse at packet end
//  underrun    out  1      1-clk pulse when the source runs dry mid-payload
// BEHAVIOUR
//  - All outputs are registered.
//  - n_rst=0 at a posedge: state=IDLE and every output = 0 after that edge, including mid-packet.
//    Latched PID, length and byte counter are cleared.
//  - FSM states: IDLE -> SYNC -> PID -> DATA -> DRAIN -> EOP -> DONE -> IDLE.
//  - IDLE, tx_start=1 at edge t:
//    - latch pid and len = min(tx_len, MAX_LEN);
//    - busy=1 from t+1.
//    - tx_start in any other state is ignored (not queued).
//  - Load decision at edge t requires all of:
//    - shift_ready=1;
//    - no load_enable at t-1 or t-2 (load pulses are therefore at least 3 clks apart);
//    - state in SYNC, PID or DATA.
//    Resulting outputs at t+1: load_enable=1 and tx_byte set.
//  - SYNC: tx_byte=SYNC_BYTE -> PID.
//  - PID: tx_byte={~pid,pid} -> DATA if len>0, else DRAIN.
//  - DATA with src_empty=0: tx_byte=src_data (sampled at t), src_pop=1 at t+1.
//    Count decrements; DRAIN after the last byte.
//  - DATA with src_empty=1 at a decision point: no load; underrun=1 at t+1; -> DRAIN.
//    Remaining bytes are dropped.
//  - DRAIN: wait for the 3-clk spacing, then shift_ready=1 (last byte fully shifted) -> EOP.
//  - EOP: eop=1 for exactly EOP_CYCLES clks -> DONE.
//  - DONE: done=1 for 1 clk; busy=0 in the same clk; -> IDLE.
//    tx_start is accepted again the next clk.
//  - Per packet: load count = 2 + bytes sent; src_pop count = bytes sent. Bytes go out in source order.
//  - shift_ready held low stalls indefinitely in any state; outputs hold and no timeout applies.
// TESTING
//  1. pid=4'h1, len=0 -> loads 0x80, 0xE1.
//     Then eop for 2 clks, done pulse, zero src_pop.
//  2. pid=4'h3, len=3, source A5,3C,FF -> loads 80,C3,A5,3C,FF.
//     3 src_pop pulses, then eop, then done.
//  3. len=4, source holds 2 bytes (BE,EF) -> loads 80,pid,BE,EF.
//     Then underrun pulse, eop 2 clks, done; src_pop=2.
//  4. len=100 -> exactly 64 payload loads (66 total).
//     A tx_start pulse mid-packet produces no second packet.
//  5. shift_ready low for 20 clks in DATA -> no loads during the stall.
//     All load_enable gaps >=3 clks across the whole packet.
//  6. n_rst=0 for one edge during DATA -> all outputs 0, busy=0.
//     A new start then sends a full packet beginning with 0x80.

Source files
------------

// File: rtl/usb_tx_packet_ctrl.sv
// Packet sequencer for the USB transmit path: feeds SYNC, PID and payload bytes to the
// shifter with at least 3 clocks between loads, then drives EOP and signals completion.
module usb_tx_packet_ctrl #(
  parameter int unsigned LEN_W      = 7,
  parameter int unsigned MAX_LEN    = 64,
  parameter logic [7:0]  SYNC_BYTE  = 8'h80,
  parameter int unsigned EOP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             tx_start,
  input  logic [3:0]       tx_pid,
  input  logic [LEN_W-1:0] tx_len,
  input  logic             src_empty,
  input  logic [7:0]       src_data,
  output logic             src_pop,
  input  logic             shift_ready,
  output logic             load_enable,
  output logic [7:0]       tx_byte,
  output logic             eop,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int unsigned EOP_W = (EOP_CYCLES > 1) ? $clog2(EOP_CYCLES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SYNC  = 3'd1,
    ST_PID   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_EOP   = 3'd5,
    ST_DONE  = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       pid_q, pid_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [EOP_W-1:0] eop_cnt_q, eop_cnt_d;
  logic             ld_d1_q, ld_d1_d;
  logic             load_enable_q, load_enable_d;
  logic [7:0]       tx_byte_q, tx_byte_d;
  logic             src_pop_q, src_pop_d;
  logic             eop_q, eop_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             underrun_q, underrun_d;
  logic             slot_ok;
  logic [LEN_W-1:0] len_clamped;

  // A load may only be decided when the shifter is ready and no load was issued in the last two clocks
  assign slot_ok     = shift_ready && !load_enable_q && !ld_d1_q;
  assign len_clamped = (tx_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tx_len;

  always_comb begin
    state_d       = state_q;
    pid_d         = pid_q;
    cnt_d         = cnt_q;
    eop_cnt_d     = eop_cnt_q;
    ld_d1_d       = load_enable_q;
    load_enable_d = 1'b0;
    tx_byte_d     = tx_byte_q;
    src_pop_d     = 1'b0;
    eop_d         = eop_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    underrun_d    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (tx_start) begin
          pid_d   = tx_pid;
          cnt_d   = len_clamped;
          busy_d  = 1'b1;
          state_d = ST_SYNC;
        end
      end
      ST_SYNC: begin
        if (slot_ok) begin
          load_enable_d = 1'b1;
          tx_byte_d     = SYNC_BYTE;
          state_d       = ST_PID;
        end
      end
      ST_PID: begin
        if (slot_ok) begin
          load_enable_d = 1'b1;
          tx_byte_d     = {~pid_q, pid_q};
          state_d       = (cnt_q != '0) ? ST_DATA : ST_DRAIN;
        end
      end
      ST_DATA: begin
        if (slot_ok) begin
          if (!src_empty) begin
            load_enable_d = 1'b1;
            tx_byte_d     = src_data;
            src_pop_d     = 1'b1;
            cnt_d         = cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_d = ST_DRAIN;
            end
          end else begin
            // Source ran dry: drop the rest of the payload and close the packet
            underrun_d = 1'b1;
            cnt_d      = '0;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (slot_ok) begin
          eop_d     = 1'b1;
          eop_cnt_d = '0;
          state_d   = ST_EOP;
        end
      end
      ST_EOP: begin
        if (eop_cnt_q == EOP_W'(EOP_CYCLES - 1)) begin
          eop_d   = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          eop_cnt_d = eop_cnt_q + EOP_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      pid_q         <= '0;
      cnt_q         <= '0;
      eop_cnt_q     <= '0;
      ld_d1_q       <= 1'b0;
      load_enable_q <= 1'b0;
      tx_byte_q     <= '0;
      src_pop_q     <= 1'b0;
      eop_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      pid_q         <= pid_d;
      cnt_q         <= cnt_d;
      eop_cnt_q     <= eop_cnt_d;
      ld_d1_q       <= ld_d1_d;
      load_enable_q <= load_enable_d;
      tx_byte_q     <= tx_byte_d;
      src_pop_q     <= src_pop_d;
      eop_q         <= eop_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign load_enable = load_enable_q;
  assign tx_byte     = tx_byte_q;
  assign src_pop     = src_pop_q;
  assign eop         = eop_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_usb_tx_packet_ctrl.sv
// Directed bench for usb_tx_packet_ctrl: byte-source model, output monitor and one task per scenario.
module tb_usb_tx_packet_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       tx_start = 1'b0;
  logic [3:0] tx_pid = 4'h0;
  logic [6:0] tx_len = 7'd0;
  logic       src_empty = 1'b1;
  logic [7:0] src_data = 8'h00;
  logic       src_pop;
  logic       shift_ready = 1'b1;
  logic       load_enable;
  logic [7:0] tx_byte;
  logic       eop;
  logic       busy;
  logic       done;
  logic       underrun;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] src_q[$];
  logic [7:0] loads[$];
  int pops, unds, eops, dones, overlap, cyc, last_load, min_gap;

  usb_tx_packet_ctrl dut (
    .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_pid(tx_pid), .tx_len(tx_len),
    .src_empty(src_empty), .src_data(src_data), .src_pop(src_pop), .shift_ready(shift_ready),
    .load_enable(load_enable), .tx_byte(tx_byte), .eop(eop), .busy(busy), .done(done),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Byte source: head advances on each sampled pop
  always @(posedge clk) begin
    if (src_pop && src_q.size() != 0) void'(src_q.pop_front());
    src_empty <= (src_q.size() == 0);
    src_data  <= (src_q.size() != 0) ? src_q[0] : 8'h00;
  end

  // Output monitor sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (load_enable) begin
      loads.push_back(tx_byte);
      if (last_load >= 0 && (cyc - last_load) < min_gap) min_gap = cyc - last_load;
      last_load = cyc;
    end
    if (src_pop) pops++;
    if (underrun) unds++;
    if (eop) eops++;
    if (done) dones++;
    if (done && busy) overlap++;
  end

  task automatic clr_mon();
    loads.delete();
    pops = 0; unds = 0; eops = 0; dones = 0; overlap = 0;
    last_load = -1; min_gap = 1000;
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic start_pkt(input logic [3:0] pid, input logic [6:0] len);
    @(negedge clk);
    tx_start = 1'b1; tx_pid = pid; tx_len = len;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (dones > 0) begin ok = 1'b1; break; end
    end
    repeat (6) step();
  endtask

  task automatic wait_loads(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (loads.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (3) step();
    vectors++;
    if ({load_enable, src_pop, eop, busy, done, underrun, tx_byte} !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 0", {load_enable, src_pop, eop, busy, done, underrun, tx_byte});
    end
    n_rst = 1'b1;
    step();
  endtask

  task automatic test_zero_len();
    bit ok;
    clr_mon();
    start_pkt(4'h1, 7'd0);
    step();
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL zl_busy got %b want 1", busy); end
    wait_done(200, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL zl_timeout got no done want done"); end
    vectors++;
    if (loads.size() != 2 || loads[0] !== 8'h80 || loads[1] !== 8'hE1) begin
      miscompares++; $display("FAIL zl_loads got %p want '{80,e1}", loads);
    end
    vectors++;
    if (eops != 2 || dones != 1 || pops != 0 || overlap != 0) begin
      miscompares++;
      $display("FAIL zl_counts got eop=%0d done=%0d pop=%0d ovl=%0d want 2 1 0 0", eops, dones, pops, overlap);
    end
  endtask

  task automatic test_short_payload();
    bit ok;
    clr_mon();
    src_q = '{8'hA5, 8'h3C, 8'hFF};
    start_pkt(4'h3, 7'd3);
    wait_done(300, ok);
    vectors++;
    if (!ok || loads.size() != 5 || loads[0] !== 8'h80 || loads[1] !== 8'hC3 ||
        loads[2] !== 8'hA5 || loads[3] !== 8'h3C || loads[4] !== 8'hFF) begin
      miscompares++; $display("FAIL sp_loads got %p want '{80,c3,a5,3c,ff}", loads);
    end
    vectors++;
    if (pops != 3 || eops != 2 || dones != 1 || unds != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sp_counts got pop=%0d eop=%0d done=%0d und=%0d busy=%b want 3 2 1 0 0",
               pops, eops, dones, unds, busy);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    clr_mon();
    src_q = '{8'hBE, 8'hEF};
    start_pkt(4'h5, 7'd4);
    wait_done(300, ok);
    vectors++;
    if (!ok || loads.size() != 4 || loads[0] !== 8'h80 || loads[1] !== 8'hA5 ||
        loads[2] !== 8'hBE || loads[3] !== 8'hEF) begin
      miscompares++; $display("FAIL ur_loads got %p want '{80,a5,be,ef}", loads);
    end
    vectors++;
    if (unds != 1 || pops != 2 || eops != 2 || dones != 1) begin
      miscompares++;
      $display("FAIL ur_counts got und=%0d pop=%0d eop=%0d done=%0d want 1 2 2 1", unds, pops, eops, dones);
    end
  endtask

  task automatic test_clamp_and_ignore_start();
    bit ok;
    int bad;
    clr_mon();
    src_q.delete();
    for (int i = 0; i < 70; i++) src_q.push_back(8'(i + 1));
    start_pkt(4'h2, 7'd100);
    repeat (40) step();
    tx_start = 1'b1; tx_pid = 4'hF; tx_len = 7'd1;
    step();
    tx_start = 1'b0;
    wait_done(1000, ok);
    repeat (30) step();
    vectors++;
    if (!ok || loads.size() != 66 || loads[1] !== 8'hD2) begin
      miscompares++; $display("FAIL cl_count got %0d loads want 66 (pid byte d2)", loads.size());
    end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (i + 2 >= loads.size() || loads[i + 2] !== 8'(i + 1)) bad++;
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL cl_order got %0d bad bytes want 0", bad); end
    vectors++;
    if (dones != 1 || pops != 64 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL cl_no_second got done=%0d pop=%0d busy=%b want 1 64 0", dones, pops, busy);
    end
    src_q.delete();
    repeat (2) step();
  endtask

  task automatic test_stall_spacing();
    bit ok;
    int n;
    clr_mon();
    src_q = '{8'h11, 8'h22, 8'h33, 8'h44};
    start_pkt(4'h7, 7'd4);
    wait_loads(3, 100, ok);
    shift_ready = 1'b0;
    step();
    n = loads.size();
    repeat (20) step();
    vectors++;
    if (!ok || loads.size() != n) begin
      miscompares++; $display("FAIL st_stall got %0d loads want %0d", loads.size(), n);
    end
    shift_ready = 1'b1;
    wait_done(300, ok);
    vectors++;
    if (!ok || loads.size() != 6 || loads[0] !== 8'h80 || loads[1] !== 8'h87 || loads[2] !== 8'h11 ||
        loads[3] !== 8'h22 || loads[4] !== 8'h33 || loads[5] !== 8'h44) begin
      miscompares++; $display("FAIL st_loads got %p want '{80,87,11,22,33,44}", loads);
    end
    vectors++;
    if (min_gap < 3) begin miscompares++; $display("FAIL st_gap got %0d want >=3", min_gap); end
  endtask

  task automatic test_mid_reset();
    bit ok;
    clr_mon();
    src_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    start_pkt(4'h9, 7'd5);
    wait_loads(3, 100, ok);
    @(negedge clk);
    n_rst = 1'b0;
    step();
    vectors++;
    if (!ok || {load_enable, src_pop, eop, busy, done, underrun, tx_byte} !== 14'h0) begin
      miscompares++;
      $display("FAIL mr_outputs got %b want 0", {load_enable, src_pop, eop, busy, done, underrun, tx_byte});
    end
    n_rst = 1'b1;
    src_q.delete();
    repeat (3) step();
    clr_mon();
    src_q = '{8'h77};
    start_pkt(4'h6, 7'd1);
    wait_done(300, ok);
    vectors++;
    if (!ok || loads.size() != 3 || loads[0] !== 8'h80 || loads[1] !== 8'h96 || loads[2] !== 8'h77) begin
      miscompares++; $display("FAIL mr_restart got %p want '{80,96,77}", loads);
    end
  endtask

  initial begin
    cyc = 0;
    clr_mon();
    test_reset();
    test_zero_len();
    test_short_payload();
    test_underrun();
    test_clamp_and_ignore_start();
    test_stall_spacing();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
